// File: rtl/led_pattern_sequencer.sv
// LED pattern memory round: shows an LFSR target, collects the player entry,
// runs a two-strike compare and keeps the pass flag and score.
module led_pattern_sequencer #(
  parameter int unsigned SHOW_CYCLES = 50_000_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        submit,
  input  logic [15:0] sw,
  input  logic        is_equal,
  output logic [15:0] led,
  output logic [15:0] amp,
  output logic [15:0] bmp,
  output logic        cmp_enable,
  output logic        busy,
  output logic        result_valid,
  output logic        pass,
  output logic [7:0]  score
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHOW  = 3'd1;
  localparam logic [2:0] S_INPUT = 3'd2;
  localparam logic [2:0] S_CMP   = 3'd3;
  localparam logic [2:0] S_RES   = 3'd4;

  localparam int CW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [2:0]    state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [CW-1:0] show_cnt_q, show_cnt_d;
  logic [1:0]    cmp_cnt_q, cmp_cnt_d;
  logic [15:0]   amp_q, amp_d;
  logic [15:0]   bmp_q, bmp_d;
  logic          pass_q, pass_d;
  logic [7:0]    score_q, score_d;
  logic [15:0]   lfsr_step;

  assign lfsr_step = {1'b0, lfsr_q[15:1]}
                   ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    show_cnt_d = show_cnt_q;
    cmp_cnt_d  = cmp_cnt_q;
    amp_d      = amp_q;
    bmp_d      = bmp_q;
    pass_d     = pass_q;
    score_d    = score_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SHOW;
          lfsr_d     = lfsr_step;
          pass_d     = 1'b0;
          show_cnt_d = '0;
        end
      end
      S_SHOW: begin
        if (show_cnt_q == SHOW_LAST) begin
          state_d    = S_INPUT;
          show_cnt_d = '0;
        end else begin
          show_cnt_d = show_cnt_q + CW'(1);
        end
      end
      S_INPUT: begin
        if (submit) begin
          amp_d     = sw;
          bmp_d     = lfsr_q;
          cmp_cnt_d = 2'd0;
          state_d   = S_CMP;
        end
      end
      S_CMP: begin
        cmp_cnt_d = cmp_cnt_q + 2'd1;
        // verdict is valid only after the second strike
        if (cmp_cnt_q == 2'd3) begin
          state_d = S_RES;
          pass_d  = is_equal;
          if (is_equal && (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
          end
        end
      end
      S_RES:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED;
      show_cnt_q <= '0;
      cmp_cnt_q  <= 2'd0;
      amp_q      <= 16'h0000;
      bmp_q      <= 16'h0000;
      pass_q     <= 1'b0;
      score_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      show_cnt_q <= show_cnt_d;
      cmp_cnt_q  <= cmp_cnt_d;
      amp_q      <= amp_d;
      bmp_q      <= bmp_d;
      pass_q     <= pass_d;
      score_q    <= score_d;
    end
  end

  always_comb begin
    led = 16'h0000;
    case (state_q)
      S_SHOW:  led = lfsr_q;
      S_INPUT: led = sw;
      S_CMP:   led = amp_q;
      S_RES:   led = pass_q ? 16'hFFFF : 16'h0000;
      default: led = 16'h0000;
    endcase
  end

  assign cmp_enable   = (state_q == S_CMP) && !cmp_cnt_q[0];
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_RES);
  assign amp          = amp_q;
  assign bmp          = bmp_q;
  assign pass         = pass_q;
  assign score        = score_q;

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Game-side initiator for the LED pattern memory round.
- Generates a pseudo-random 16-bit target pattern and shows it on the LEDs for a fixed time, then mirrors the switches while the player enters the pattern.
- On submit, drives the operand pair and enable strobes into the downstream equality comparator, then collects its is_equal verdict.
- Keeps a pass/fail flag and a running score.

Parameters:
- SHOW_CYCLES, 50_000_000: clock cycles the target pattern stays on the LEDs. Minimum 1.
- LFSR_SEED, 16'hACE1: LFSR value loaded at reset. A value of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a round.
- submit  in  1  one-cycle pulse that locks in the player entry.
- sw  in  16  player switch inputs.
- is_equal  in  1  comparator verdict, registered in the comparator.
- led  out  16  LED drive.
- amp  out  16  comparator operand A (player entry).
- bmp  out  16  comparator operand B (target).
- cmp_enable  out  1  comparator enable strobe.
- busy  out  1  high whenever state is not IDLE.
- result_valid  out  1  one-cycle pulse when the verdict is final.
- pass  out  1  verdict of the last round.
- score  out  8  count of passed rounds.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, lfsr=LFSR_SEED (or 16'h0001 if the seed is 0).
  - led, amp, bmp, score = 0.
  - cmp_enable, busy, result_valid, pass = 0.
  - Show counter = 0.
- LFSR: 16-bit Galois, right shift. next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Steps exactly once per accepted start. The stepped value is the round target.
- IDLE:
  - led=0.
  - start moves to SHOW next cycle, steps the LFSR, clears pass.
  - submit is ignored. If start and submit arrive together, start wins and submit is dropped.
- SHOW:
  - led=target for exactly SHOW_CYCLES cycles.
  - The counter counts 0..SHOW_CYCLES-1, then the state moves to INPUT.
  - start and submit are ignored.
- INPUT:
  - led=sw, combinational mirror. Waits with no timeout.
  - submit registers amp<=sw and bmp<=target, then moves to COMPARE.
  - start is ignored.
- COMPARE: fixed 4-cycle sequence.
  - The comparator latches its operands on one enable strike and evaluates them on the next strike, so is_equal lags by one strike. This block therefore issues two strikes.
  - C0: cmp_enable=1.
  - C1: cmp_enable=0, which releases the comparator lock.
  - C2: cmp_enable=1.
  - C3: cmp_enable=0; sample is_equal at the end of C3.
  - amp and bmp are held stable through the whole sequence.
  - led shows the frozen entry (amp).
- RESULT: one cycle.
  - result_valid=1, pass=sampled is_equal.
  - On pass, score increments, saturating at 255. Score is otherwise unchanged.
  - led=16'hFFFF on pass, 16'h0000 on fail.
  - Then return to IDLE.
- pass, amp, bmp and score hold their values until the next start or reset. Score never clears except on reset.
- busy is registered-equivalent: high from the cycle after start up to and including the RESULT cycle.
- Reset mid-round (any state) aborts immediately.
  - cmp_enable drops in the same instant, with no partial strike completion.
  - The next round needs a fresh start.

Test Plan:
1. Reset, then start, with SHOW_CYCLES=4 and seed 16'hACE1 → target 16'hE270; led=16'hE270 for exactly 4 cycles; busy=1; then led mirrors sw.
2. In INPUT, set sw=16'hE270 and pulse submit (comparator model includes the one-strike lag) → cmp_enable pattern 1,0,1,0 with amp=bmp=16'hE270; result_valid pulses once; pass=1; score=1; led=16'hFFFF for 1 cycle.
3. Second round: start → target 16'h7138. Enter sw=16'h7139 and submit → pass=0, score stays 1, led=0 in RESULT.
4. Pulse start and submit during SHOW, pulse submit in IDLE, and pulse start simultaneously with submit in IDLE → stray pulses are ignored; round timing is unchanged; state goes IDLE→SHOW with no compare.
5. Force score=255 via repeated passing rounds, then pass once more → score stays 255.
6. Assert rst during COMPARE cycle C2 → cmp_enable=0, busy=0, score=0, lfsr=16'hACE1 immediately; the next start gives target 16'hE270 again.
